divider_radix: RTL and testbench

DIVIDER_RADIX -- requirements
Module: divider_radix

---
 rtl/divider_pkg.sv | 18 +
 rtl/div_step.sv | 32 +++
 rtl/divider_radix.sv | 146 ++++++++++++++
 tb/tb_divider_radix.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
//------------------------------------------------------------------------------
// Module   : divider_pkg
// Purpose  : Shared state encoding for the radix divider.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package divider_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIVIDING = 2'd1,
        FIXUP    = 2'd2
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
//------------------------------------------------------------------------------
// Module   : div_step
// Purpose  : One combinational restoring-division step (one quotient bit).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module div_step
    import divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit_out
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    // rem_in < divisor, so the shifted value fits in WIDTH+1 bits and the top
    // bit of the difference is a clean borrow flag.
    assign w_shifted = {rem_in, bit_in};
    assign w_diff    = w_shifted - {1'b0, divisor_in};
    assign q_bit_out = ~w_diff[WIDTH];
    assign rem_out   = q_bit_out ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/divider_radix.sv
//------------------------------------------------------------------------------
// Module   : divider_radix
// Purpose  : Iterative signed/unsigned divider retiring BITS_PER_CYCLE bits/cycle.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module divider_radix
    import divider_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    input  logic             signed_in,
    input  logic             data_valid_in,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out,
    output logic             data_valid_out,
    output logic             error_out,
    output logic             busy_out
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 4 || (WIDTH % 2) != 0 || BITS_PER_CYCLE < 1 ||
            (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
            $error("divider_radix: illegal WIDTH/BITS_PER_CYCLE combination");
        end
    endgenerate

    div_state_t       r_state;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_valid;
    logic             r_error;
    logic             r_busy;

    logic [WIDTH-1:0]          w_rem [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] w_qbits;
    logic [WIDTH-1:0]          w_dvd_next;
    logic [WIDTH-1:0]          w_q_final;
    logic [WIDTH-1:0]          w_r_final;
    logic [WIDTH-1:0]          w_dvd_mag;
    logic [WIDTH-1:0]          w_dvs_mag;

    assign w_dvd_mag = (signed_in && dividend_in[WIDTH-1]) ? -dividend_in : dividend_in;
    assign w_dvs_mag = (signed_in && divisor_in[WIDTH-1])  ? -divisor_in  : divisor_in;

    assign w_rem[0] = r_rem;

    // r_dvd holds the not-yet-consumed dividend bits on top and the retired
    // quotient bits filling in from the bottom.
    generate
        for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
            div_step #(.WIDTH(WIDTH)) u_step (
                .rem_in     (w_rem[k]),
                .bit_in     (r_dvd[WIDTH-1-k]),
                .divisor_in (r_dvs),
                .rem_out    (w_rem[k+1]),
                .q_bit_out  (w_qbits[BITS_PER_CYCLE-1-k])
            );
        end
    endgenerate

    assign w_dvd_next = (r_dvd << BITS_PER_CYCLE) | WIDTH'(w_qbits);
    assign w_q_final  = r_neg_q ? -w_dvd_next : w_dvd_next;
    assign w_r_final  = r_neg_r ? -w_rem[BITS_PER_CYCLE] : w_rem[BITS_PER_CYCLE];

    // FIXUP is the result-presentation cycle; it is not busy, so a new request
    // can be taken there for N+1-cycle back-to-back throughput.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= IDLE;
            r_dvd       <= '0;
            r_rem       <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                DIVIDING: begin
                    r_dvd <= w_dvd_next;
                    r_rem <= w_rem[BITS_PER_CYCLE];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_quotient  <= w_q_final;
                        r_remainder <= w_r_final;
                        r_error     <= 1'b0;
                        r_valid     <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= FIXUP;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    if (data_valid_in) begin
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_neg_q <= signed_in & (dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1]);
                        r_neg_r <= signed_in & dividend_in[WIDTH-1];
                        r_dvd   <= w_dvd_mag;
                        r_dvs   <= w_dvs_mag;
                        if (divisor_in == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend_in;
                            r_error     <= 1'b1;
                            r_valid     <= 1'b1;
                            r_state     <= FIXUP;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= DIVIDING;
                        end
                    end
                end
            endcase
        end
    end

    assign quotient_out   = r_quotient;
    assign remainder_out  = r_remainder;
    assign data_valid_out = r_valid;
    assign error_out      = r_error;
    assign busy_out       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_divider_radix.sv
//------------------------------------------------------------------------------
// Module   : tb_divider_radix
// Purpose  : Self-checking bench for divider_radix (B=2 main, B=1/B=4 random).
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_divider_radix;

    localparam int W = 32;

    logic           clk_in = 1'b0;
    logic           rst_n_in;
    logic [W-1:0]   dividend_in;
    logic [W-1:0]   divisor_in;
    logic           signed_in;
    logic           data_valid_in;

    // index 0: B=2, index 1: B=1, index 2: B=4
    logic [2:0][W-1:0] q_o;
    logic [2:0][W-1:0] r_o;
    logic [2:0]        v_o;
    logic [2:0]        e_o;
    logic [2:0]        b_o;

    int checks = 0;
    int errors = 0;
    int lat_norm [3] = '{17, 33, 9};

    always #5 clk_in = ~clk_in;

    divider_radix #(.WIDTH(W), .BITS_PER_CYCLE(2)) u_dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .dividend_in(dividend_in),
        .divisor_in(divisor_in), .signed_in(signed_in), .data_valid_in(data_valid_in),
        .quotient_out(q_o[0]), .remainder_out(r_o[0]), .data_valid_out(v_o[0]),
        .error_out(e_o[0]), .busy_out(b_o[0]));

    divider_radix #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut_b1 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .dividend_in(dividend_in),
        .divisor_in(divisor_in), .signed_in(signed_in), .data_valid_in(data_valid_in),
        .quotient_out(q_o[1]), .remainder_out(r_o[1]), .data_valid_out(v_o[1]),
        .error_out(e_o[1]), .busy_out(b_o[1]));

    divider_radix #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut_b4 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .dividend_in(dividend_in),
        .divisor_in(divisor_in), .signed_in(signed_in), .data_valid_in(data_valid_in),
        .quotient_out(q_o[2]), .remainder_out(r_o[2]), .data_valid_out(v_o[2]),
        .error_out(e_o[2]), .busy_out(b_o[2]));

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic         sgn;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         err;
        int           lat;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Independent reference: truncating division via 64-bit arithmetic.
    function automatic logic [64:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
        longint       sa;
        longint       sb;
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {1'b0, q, r};
    endfunction

    // Cycle 1 is the first cycle after the accept edge.
    task automatic run_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sgn,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ee,
                          input int elat, input string name);
        int cyc;
        int busy_cnt;
        dividend_in   = dvd;
        divisor_in    = dvs;
        signed_in     = sgn;
        data_valid_in = 1'b1;
        tick();
        data_valid_in = 1'b0;
        dividend_in   = ~dvd;
        divisor_in    = 32'h3;
        signed_in     = ~sgn;
        cyc      = 1;
        busy_cnt = 0;
        while (v_o[0] !== 1'b1 && cyc < 45) begin
            if (b_o[0] === 1'b1) busy_cnt++;
            tick();
            cyc++;
        end
        check({name, " latency"}, 96'(cyc), 96'(elat));
        check({name, " busy_cycles"}, 96'(busy_cnt), 96'(elat - 1));
        check({name, " busy_at_valid"}, 96'(b_o[0]), 96'(0));
        check({name, " result"}, {31'b0, e_o[0], q_o[0], r_o[0]}, {31'b0, ee, eq, er});
    endtask

    initial begin
        int cyc;
        int nseen;
        logic [2:0] seen;
        logic [64:0] exp;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic s;

        vecs[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 17};
        vecs[1]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 17};
        vecs[2]  = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 17};
        vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 17};
        vecs[4]  = '{32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 32'd5,        1'b1, 1};
        vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 1'b0, 17};
        vecs[6]  = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 17};
        vecs[7]  = '{32'd3,        32'd10,       1'b0, 32'd0,        32'd3,        1'b0, 17};
        vecs[8]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE, 1'b0, 17};
        vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1,        32'd0,        1'b0, 17};
        vecs[10] = '{32'hFFFFFFF9, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1};
        vecs[11] = '{32'h80000000, 32'd2,        1'b1, 32'hC0000000, 32'd0,        1'b0, 17};

        rst_n_in      = 1'b0;
        dividend_in   = '0;
        divisor_in    = '0;
        signed_in     = 1'b0;
        data_valid_in = 1'b0;
        repeat (3) tick();
        check("reset_state", {29'b0, v_o[0], e_o[0], b_o[0], q_o[0], r_o[0]}, 96'(0));

        // First request lands on the first edge after reset release.
        rst_n_in = 1'b1;
        for (int i = 0; i < 12; i++)
            run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].sgn, vecs[i].q, vecs[i].r,
                   vecs[i].err, vecs[i].lat, $sformatf("vec%0d", i));

        // Back-to-back with data_valid_in held high; B operands wait while A runs.
        dividend_in   = 32'd100;
        divisor_in    = 32'd7;
        signed_in     = 1'b0;
        data_valid_in = 1'b1;
        tick();
        dividend_in = 32'd1000;
        divisor_in  = 32'd3;
        cyc = 1;
        while (v_o[0] !== 1'b1 && cyc < 45) begin tick(); cyc++; end
        check("b2b_a latency", 96'(cyc), 96'(17));
        check("b2b_a result", {31'b0, e_o[0], q_o[0], r_o[0]}, {31'b0, 1'b0, 32'd14, 32'd2});
        tick();
        cyc = 1;
        while (v_o[0] !== 1'b1 && cyc < 45) begin tick(); cyc++; end
        check("b2b_b latency", 96'(cyc), 96'(17));
        check("b2b_b result", {31'b0, e_o[0], q_o[0], r_o[0]}, {31'b0, 1'b0, 32'd333, 32'd1});
        data_valid_in = 1'b0;
        tick();
        check("b2b_no_extra_accept", 96'(b_o[0]), 96'(0));

        // Reset during cycle 5 of an operation.
        dividend_in   = 32'd100;
        divisor_in    = 32'd7;
        data_valid_in = 1'b1;
        tick();
        data_valid_in = 1'b0;
        repeat (4) tick();
        rst_n_in = 1'b0;
        #1;
        check("midop_reset_outputs", {29'b0, v_o[0], e_o[0], b_o[0], q_o[0], r_o[0]}, 96'(0));
        tick();
        tick();
        rst_n_in = 1'b1;
        run_op(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0, 17, "after_reset");

        // Random operands across three radices against the reference model.
        data_valid_in = 1'b0;
        repeat (40) tick();
        for (int n = 0; n < 1500; n++) begin
            a = $urandom;
            if ($urandom_range(0, 15) == 0) a = 32'h80000000;
            case ($urandom_range(0, 9))
                0:       b = '0;
                1:       b = 32'hFFFFFFFF;
                2:       b = $urandom & 32'hFF;
                3, 4:    b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            s   = 1'($urandom_range(0, 1));
            exp = ref_div(a, b, s);
            dividend_in   = a;
            divisor_in    = b;
            signed_in     = s;
            data_valid_in = 1'b1;
            tick();
            data_valid_in = 1'b0;
            cyc   = 1;
            nseen = 0;
            seen  = '0;
            while (nseen < 3 && cyc <= 40) begin
                for (int i = 0; i < 3; i++) begin
                    if (!seen[i] && v_o[i] === 1'b1) begin
                        seen[i] = 1'b1;
                        nseen++;
                        check($sformatf("rand%0d_u%0d %h/%h s%0d", n, i, a, b, s),
                              {31'b0, e_o[i], q_o[i], r_o[i]}, {31'b0, exp});
                        check($sformatf("rand%0d_u%0d latency", n, i), 96'(cyc),
                              96'((b == '0) ? 1 : lat_norm[i]));
                    end
                end
                if (nseen < 3) begin
                    tick();
                    cyc++;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (!seen[i]) begin
                    checks++;
                    errors++;
                    $display("FAIL rand%0d_u%0d timeout actual=no_valid required=valid", n, i);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
